// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Optional round-robin arbitration is enabled by DMEM_ARB_RR_EN.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 16;
  localparam int MEM_DEPTH_DEF = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way request pick: fixed priority to port 0, or round-robin
// against last_grant when DMEM_ARB_RR_EN is defined.
module dmem_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic winner,
  output logic valid
);

  assign valid = req0 | req1;

`ifdef DMEM_ARB_RR_EN
  assign winner = (req0 & req1) ? ~last_grant : req1;
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign winner = ~req0 & req1;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises CPU and DMA accesses onto the single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin instead of fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MEM_DEPTH);

  state_t state, state_nx;

  logic              last_grant;
  logic              win, win_v, take;
  logic              own, we_q, ok_q, err_q, rsp;
  logic [DATA_W-1:0] rdata_q;
  logic              c_we, c_ok;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;

  dmem_arb_pick u_pick (
    .req0      (p0_req),
    .req1      (p1_req),
    .last_grant(last_grant),
    .winner    (win),
    .valid     (win_v)
  );

  assign c_we    = win ? p1_we    : p0_we;
  assign c_addr  = win ? p1_addr  : p0_addr;
  assign c_wdata = win ? p1_wdata : p0_wdata;
  assign c_ok    = c_addr < DEPTH;

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_v && rst_n) begin
          state_nx = ACCESS;
          take     = 1'b1;
        end
      end
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      own             <= PORT_CPU;
      we_q            <= 1'b0;
      ok_q            <= 1'b0;
      err_q           <= 1'b0;
      rdata_q         <= '0;
      mem_access_addr <= '0;
      mem_write_data  <= '0;
      mem_write_en    <= 1'b0;
      mem_read        <= 1'b0;
    end else begin
      state        <= state_nx;
      mem_write_en <= 1'b0;
      mem_read     <= 1'b0;
      if (take) begin
        own             <= win;
        we_q            <= c_we;
        ok_q            <= c_ok;
        mem_access_addr <= c_addr;
        mem_write_data  <= c_wdata;
        mem_write_en    <= c_we & c_ok;
        mem_read        <= ~c_we & c_ok;
      end
      // Out-of-range or write: never expose memory data.
      if (state == ACCESS) begin
        rdata_q <= (~we_q & ok_q) ? mem_read_data : '0;
        err_q   <= ~ok_q;
      end
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= PORT_DMA;
    end else if (take) begin
      last_grant <= win;
    end
  end
`else
  assign last_grant = PORT_DMA;
`endif

  assign rsp = state == RESP;

  assign p0_gnt    = take & (win == PORT_CPU);
  assign p1_gnt    = take & (win == PORT_DMA);
  assign p0_rvalid = rsp & (own == PORT_CPU);
  assign p1_rvalid = rsp & (own == PORT_DMA);
  assign p0_rdata  = p0_rvalid ? rdata_q : '0;
  assign p1_rdata  = p1_rvalid ? rdata_q : '0;
  assign p0_err    = p0_rvalid & err_q;
  assign p1_err    = p1_rvalid & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a transaction-level model.
// Build with DMEM_ARB_RR_EN to check the round-robin variant.
module tb_dmem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MD = 8;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n;
  logic p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
  logic p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
  logic [AW-1:0] p0_addr, p1_addr, mem_access_addr;
  logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic [DW-1:0] mem_write_data, mem_read_data;
  logic mem_write_en, mem_read;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read),
    .mem_read_data(mem_read_data)
  );

  // Data memory: combinational read, junk outside the implemented range.
  logic [DW-1:0] mem [MD];
  logic [DW-1:0] seed_mem [MD];
  bit loaded = 1'b0;

  assign mem_read_data = (mem_access_addr < AW'(MD)) ?
                         mem[mem_access_addr[2:0]] : 16'hDEAD;

  always @(posedge clk) begin
    if (!loaded) begin
      mem    <= seed_mem;
      loaded <= 1'b1;
    end else if (mem_write_en && mem_access_addr < AW'(MD)) begin
      mem[mem_access_addr[2:0]] <= mem_write_data;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: each grant schedules a strobe one cycle later and a
  // response two cycles later; the arbiter is free again three cycles on.
  logic [DW-1:0] ref_mem [MD];
  int   cyc = 0;
  int   free_at = 0;
  bit   lg = 1'b1;
  bit   s_v = 1'b0, s_we, s_ok;
  int   s_cyc = -1;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wd;
  bit   r_v = 1'b0, r_port, r_err;
  int   r_cyc = -1;
  logic [DW-1:0] r_data;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0;
  bit   mg0 = 1'b0, mg1 = 1'b0;
  int   gl_port[$];
  int   gl_cyc[$];

  always @(negedge clk) begin : model
    bit g0, g1, sv, rv, r0, r1;
    #2;
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_n && cyc >= free_at) begin
      if (p0_req && p1_req) begin
`ifdef DMEM_ARB_RR_EN
        if (lg) g0 = 1'b1;
        else g1 = 1'b1;
`else
        g0 = 1'b1;
`endif
      end else begin
        g0 = p0_req;
        g1 = p1_req;
      end
    end
    sv = s_v && s_cyc == cyc;
    rv = r_v && r_cyc == cyc;
    r0 = rv && !r_port;
    r1 = rv && r_port;
    chk("p0_gnt", p0_gnt, g0);
    chk("p1_gnt", p1_gnt, g1);
    chk("mem_write_en", mem_write_en, sv && s_we && s_ok);
    chk("mem_read", mem_read, sv && !s_we && s_ok);
    chk("mem_access_addr", mem_access_addr, m_addr);
    chk("mem_write_data", mem_write_data, m_wd);
    chk("p0_rvalid", p0_rvalid, r0);
    chk("p0_rdata", p0_rdata, r0 ? r_data : '0);
    chk("p0_err", p0_err, r0 && r_err);
    chk("p1_rvalid", p1_rvalid, r1);
    chk("p1_rdata", p1_rdata, r1 ? r_data : '0);
    chk("p1_err", p1_err, r1 && r_err);
    if (sv) begin
      if (s_we && s_ok) ref_mem[s_addr[2:0]] = s_wd;
      r_data = (!s_we && s_ok) ? ref_mem[s_addr[2:0]] : '0;
      r_err  = !s_ok;
    end
    if (g0 || g1) begin
      s_v    = 1'b1;
      s_cyc  = cyc + 1;
      s_we   = g1 ? p1_we : p0_we;
      s_addr = g1 ? p1_addr : p0_addr;
      s_wd   = g1 ? p1_wdata : p0_wdata;
      s_ok   = s_addr < AW'(MD);
      r_v    = 1'b1;
      r_cyc  = cyc + 2;
      r_port = g1;
      free_at = cyc + 3;
      lg     = g1;
      m_addr = s_addr;
      m_wd   = s_wd;
      gl_port.push_back(int'(g1));
      gl_cyc.push_back(cyc);
    end
    if (!rst_n) begin
      if (r_cyc > cyc) r_v = 1'b0;
      if (s_cyc > cyc) s_v = 1'b0;
      free_at = cyc + 1;
      lg      = 1'b1;
      m_addr  = '0;
      m_wd    = '0;
    end
    mg0 = g0;
    mg1 = g1;
    cyc++;
  end

  // Requesters: present the queue head until granted, junk otherwise.
  cmd_t q0[$];
  cmd_t q1[$];

  task automatic drive();
    if (mg0 && q0.size() > 0) void'(q0.pop_front());
    if (mg1 && q1.size() > 0) void'(q1.pop_front());
    if (q0.size() > 0) begin
      p0_req = 1'b1; p0_we = q0[0].we;
      p0_addr = q0[0].addr; p0_wdata = q0[0].wd;
    end else begin
      p0_req = 1'b0; p0_we = 1'($urandom);
      p0_addr = 16'($urandom); p0_wdata = 16'($urandom);
    end
    if (q1.size() > 0) begin
      p1_req = 1'b1; p1_we = q1[0].we;
      p1_addr = q1[0].addr; p1_wdata = q1[0].wd;
    end else begin
      p1_req = 1'b0; p1_we = 1'($urandom);
      p1_addr = 16'($urandom); p1_wdata = 16'($urandom);
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive();
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || cyc < free_at) && n < budget) begin
      step();
      n++;
    end
    tests++;
    if (n >= budget) begin
      fails++;
      $display("FAIL wait_idle: got timeout after %0d cycles, expected idle", n);
    end
  endtask

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    c.we   = 1'($urandom);
    c.addr = ($urandom_range(0, 3) == 0) ? 16'($urandom) :
             16'($urandom_range(0, 9));
    c.wd   = 16'($urandom);
    return c;
  endfunction

  initial begin
    int base;
    logic [DW-1:0] wd5;
    for (int i = 0; i < MD; i++) begin
      seed_mem[i] = 16'($urandom);
      ref_mem[i]  = seed_mem[i];
    end
    rst_n = 1'b0;
    q0.push_back('{1'b1, 16'd3, 16'hA5A5});
    q1.push_back('{1'b0, 16'd8, 16'h0000});
    drive();

    // Reset with both requests held.
    step(); #3;
    chk("rst p0_gnt", p0_gnt, 0);
    chk("rst p1_gnt", p1_gnt, 0);
    chk("rst mem_write_en", mem_write_en, 0);
    chk("rst mem_read", mem_read, 0);
    chk("rst mem_access_addr", mem_access_addr, 0);
    chk("rst p0_rvalid", p0_rvalid, 0);
    chk("rst p1_rvalid", p1_rvalid, 0);
    step(); rst_n = 1'b1; #3;
    chk("first p0_gnt", p0_gnt, 1);
    chk("first p1_gnt", p1_gnt, 0);
    step(); #3;
    chk("wr mem_write_en", mem_write_en, 1);
    chk("wr mem_access_addr", mem_access_addr, 16'd3);
    chk("wr mem_write_data", mem_write_data, 16'hA5A5);
    step(); #3;
    chk("wr p0_rvalid", p0_rvalid, 1);
    chk("wr p0_err", p0_err, 0);
    step(); #3;
    chk("oor p1_gnt", p1_gnt, 1);
    step(); #3;
    chk("oor mem_read", mem_read, 0);
    chk("oor mem_write_en", mem_write_en, 0);
    step(); #3;
    chk("oor p1_rvalid", p1_rvalid, 1);
    chk("oor p1_err", p1_err, 1);
    chk("oor p1_rdata", p1_rdata, 0);
    q0.push_back('{1'b0, 16'd3, 16'h0000});
    step(); #3;
    chk("rd p0_gnt", p0_gnt, 1);
    step(); #3;
    chk("rd mem_read", mem_read, 1);
    step(); #3;
    chk("rd p0_rvalid", p0_rvalid, 1);
    chk("rd p0_rdata", p0_rdata, 16'hA5A5);

    // Contention after a lone p1 grant.
    q1.push_back('{1'b0, 16'd1, 16'h0000});
    wait_idle(20);
    base = gl_port.size();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'($urandom), 16'($urandom_range(0, 7)), 16'($urandom)});
      q1.push_back('{1'($urandom), 16'($urandom_range(0, 7)), 16'($urandom)});
    end
    wait_idle(60);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      chk($sformatf("rr order %0d", i), gl_port[base+i], i % 2);
`else
      chk($sformatf("fixed order %0d", i), gl_port[base+i], 0);
`endif
      if (i > 0)
        chk($sformatf("grant spacing %0d", i),
            gl_cyc[base+i] - gl_cyc[base+i-1], 3);
    end

    // Reset during ACCESS of a write.
    wd5 = ref_mem[5] ^ 16'h5A5A;
    q0.push_back('{1'b1, 16'd5, wd5});
    step(); #3;
    chk("rstA p0_gnt", p0_gnt, 1);
    step(); rst_n = 1'b0; #3;
    chk("rstA mem_write_en", mem_write_en, 1);
    q1.push_back('{1'b0, 16'd5, 16'h0000});
    step(); rst_n = 1'b1; #3;
    chk("rstA p0_rvalid", p0_rvalid, 0);
    chk("rstA idle p1_gnt", p1_gnt, 1);
    chk("rstA mem5", mem[5], wd5);
    wait_idle(20);

    // Reset during RESP.
    q0.push_back('{1'b0, 16'd2, 16'h0000});
    step(); #3;
    chk("rstR p0_gnt", p0_gnt, 1);
    step();
    step(); rst_n = 1'b0; #3;
    chk("rstR p0_rvalid", p0_rvalid, 1);
    step(); rst_n = 1'b1; #3;
    chk("rstR after p0_rvalid", p0_rvalid, 0);
    wait_idle(20);

    // p1 arriving while p0 is in ACCESS waits until T+3.
    q0.push_back('{1'b0, 16'd4, 16'h0000});
    step(); #3;
    chk("late p0_gnt", p0_gnt, 1);
    q1.push_back('{1'b0, 16'd6, 16'h0000});
    step(); #3;
    chk("late p1_gnt access", p1_gnt, 0);
    step(); #3;
    chk("late p1_gnt resp", p1_gnt, 0);
    step(); #3;
    chk("late p1_gnt T+3", p1_gnt, 1);
    wait_idle(20);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step();
      rst_n = ($urandom_range(0, 59) != 0);
      if (q0.size() < 3 && $urandom_range(0, 3) == 0) q0.push_back(rnd_cmd());
      if (q1.size() < 3 && $urandom_range(0, 3) == 0) q1.push_back(rnd_cmd());
    end
    rst_n = 1'b1;
    wait_idle(100);
    step();
    for (int i = 0; i < MD; i++)
      chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the single-port data memory (`Data_Memory`). Port 0 is the CPU load/store stage; port 1 is a DMA/debug master. The arbiter serialises both onto the memory's shared address, write and read signals. It registers each command, runs the memory access, and returns read data or a write acknowledge with an out-of-range error flag.

## Interface
Parameters:
- ADDR_W, 16, address width, matching `mem_access_addr`
- DATA_W, 16, data width, matching `mem_write_data`/`mem_read_data`
- MEM_DEPTH, 8, number of implemented words; addresses >= MEM_DEPTH are out of range

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- pN_req  in  1  request from port N (N = 0, 1); held until pN_gnt
- pN_we  in  1  1 = write, 0 = read; stable while pN_req is high and pN_gnt is low
- pN_addr  in  ADDR_W  word address; stable under the same rule
- pN_wdata  in  DATA_W  write data; stable under the same rule
- pN_gnt  out  1  one-cycle pulse: command accepted, requester may change inputs next cycle
- pN_rvalid  out  1  one-cycle completion pulse for reads and writes
- pN_rdata  out  DATA_W  read data, valid with pN_rvalid; 0 for writes and errors
- pN_err  out  1  valid with pN_rvalid: address was out of range
- mem_access_addr  out  ADDR_W  to memory
- mem_write_data  out  DATA_W  to memory
- mem_write_en  out  1  to memory
- mem_read  out  1  to memory
- mem_read_data  in  DATA_W  combinational read data from memory

## Operation
- FSM with states IDLE, ACCESS, RESP. Transitions: IDLE→ACCESS when any req is high; ACCESS→RESP always; RESP→IDLE always.
- IDLE, requests pending:
  - Choose the winner and pulse its gnt combinationally in the same cycle.
  - Capture the winner's we/addr/wdata and port index into registers.
  - Set range_ok = (addr < MEM_DEPTH).
- ACCESS: the mem_* outputs are registers loaded at the IDLE→ACCESS edge.
  - mem_access_addr = captured address.
  - mem_write_en = we & range_ok.
  - mem_read = ~we & range_ok.
  - mem_write_data = captured wdata.
  - At the end of the cycle, rdata_q ← (~we & range_ok) ? mem_read_data : 0 and err_q ← ~range_ok.
- RESP:
  - The owner's rvalid is 1 for exactly one cycle, with rdata and err from the registers.
  - The other port's rvalid/err are 0 and its rdata is 0.
  - mem_write_en and mem_read are 0.
- Only one access is outstanding at a time. A req that arrives during ACCESS or RESP waits in IDLE for arbitration.
- Arbitration with both requests high in IDLE: the selection rule is set under Configuration. A single requester always wins.
- An out-of-range access performs no memory read or write and completes with err=1 and rdata=0.

## Timing
- Reset (rst_n low at an edge):
  - state ← IDLE.
  - All outputs ← 0: gnt, rvalid, err, rdata, mem_access_addr, mem_write_data, mem_write_en, mem_read.
  - last_grant ← 1, so port 0 wins the first contested arbitration.
- Latency: gnt in cycle T (IDLE), memory strobe in T+1, rvalid in T+2. Back-to-back accesses take 3 cycles each; the next gnt is possible at T+3.
- Reset mid-operation:
  - rst_n low during ACCESS: the write presented that cycle still reaches memory, because the strobe was already registered. No rvalid follows.
  - rst_n low during RESP: rvalid that cycle is still driven; state is cleared at the edge.
- gnt is combinational from req in IDLE only; it is 0 in ACCESS and RESP.
- Requester inputs are sampled only in the gnt cycle; changes afterwards have no effect.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin between the two ports.
  - last_grant updates on every gnt.
  - On contention, the port that is not last_grant wins.
- DMEM_ARB_RR_EN undefined: fixed priority.
  - Port 0 always wins on contention; last_grant is not implemented.
  - Port 1 can starve while port 0 requests continuously.

## Structure
- Shared package dmem_arb_pkg holds:
  - state enum (IDLE, ACCESS, RESP);
  - port index constants PORT_CPU = 0 and PORT_DMA = 1;
  - ADDR_W/DATA_W/MEM_DEPTH defaults matching the data memory.
- One sub-module, dmem_arb_pick: a two-way pick taking req0, req1 and last_grant and returning the winner index and valid. The DMEM_ARB_RR_EN selection lives there.

## Test plan
- Reset: hold rst_n low for 2 cycles with both req high → all outputs 0, no gnt. After release, p0_gnt in the first IDLE cycle.
- p0 write addr 3, data 16'hA5A5, then p0 read addr 3:
  - write: mem_write_en=1 for one cycle, then p0_rvalid=1 with err=0;
  - read: p0_rdata=16'hA5A5 two cycles after gnt.
- p1 read at addr 8 (MEM_DEPTH) → mem_read and mem_write_en stay 0; p1_rvalid=1, p1_err=1, p1_rdata=0.
- Both ports hold req for 4 accesses:
  - with DMEM_ARB_RR_EN, grants go p0, p1, p0, p1, spaced 3 cycles apart;
  - without it, grants go p0, p0, p0, p0 and p1 never gets a gnt.
- p0 write addr 5 with rst_n dropped during ACCESS → memory[5] is updated; no p0_rvalid; FSM is in IDLE after reset.
- p1 req rising while p0 is in ACCESS → p1_gnt is not asserted until the cycle after p0's RESP (T+3).
